// File: rtl/car_mode_ctrl_if.sv
// Purpose: carries the Zigbee command byte from the radio receiver into the mode controller.
// Latency: none, wires only.
// Backpressure: none; rx_valid is a one-cycle strobe the slave must accept.
interface car_mode_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/car_mode_ctrl.sv
// Purpose: decodes Zigbee commands into manual/auto modes; runs track, wall, park and cruise behaviours.
// Latency: command -> outputs 2 cycles; sensor change -> outputs 1 cycle; all outputs registered.
// Backpressure: none; every rx_valid strobe is consumed the cycle it arrives.
module car_mode_ctrl #(
  parameter int SPD_W        = 8,
  parameter int DIST_W       = 8,
  parameter int N_LINE       = 4,
  parameter int STARTUP_CYC  = 20_000_000,
  parameter int TICK_CYC     = 6_250_000,
  parameter int DEG_STRAIGHT = 95,
  parameter int DEG_LEFT     = 120,
  parameter int DEG_RIGHT    = 60,
  parameter int MAN_HI       = 30,
  parameter int MAN_LO       = 15,
  parameter int PARK_NEAR    = 35,
  parameter int PARK_SIDE    = 30,
  parameter int PARK_STOP    = 9,
  parameter int WALL_NEAR    = 20,
  parameter int FWD_TICKS    = 11,
  parameter int WALL_TICKS   = 10
) (
  input  logic                clk_50M,
  input  logic                rst,
  car_mode_ctrl_if.slave      rx,
  input  logic [SPD_W-1:0]    button,
  input  logic [DIST_W-1:0]   fwd_dist,
  input  logic [DIST_W-1:0]   back_dist,
  input  logic [1:0]          touch,
  input  logic [1:0]          side_ir,
  input  logic [N_LINE-1:0]   line_ir,
  input  logic [1:0]          signs,
  output logic [SPD_W-1:0]    speed,
  output logic [8:0]          degree,
  output logic                direction,
  output logic                beep_en,
  output logic [SPD_W-1:0]    display,
  output logic [23:0]         light,
  output logic [1:0]          mode,
  output logic [1:0]          sub_state,
  output logic [2:0]          park_state
);

  typedef enum logic [1:0] {M_MANUAL = 2'b00, M_SPDSET = 2'b01, M_FUNC = 2'b10, M_AUTO = 2'b11} mode_t;
  typedef enum logic [1:0] {S_TRACK = 2'b00, S_WALL = 2'b01, S_PARK = 2'b10, S_CRUISE = 2'b11} sub_t;
  typedef enum logic [2:0] {P_IDLE = 3'd0, P_BACK1 = 3'd1, P_FWD = 3'd2, P_BACK2 = 3'd3, P_DONE = 3'd4} park_t;

  localparam int HOLD_W  = (STARTUP_CYC > 0) ? $clog2(STARTUP_CYC + 1) : 1;
  localparam int TICK_W  = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int TIMER_W = 8;
  localparam int CNT_W   = $clog2(N_LINE / 2 + 1);

  localparam logic [8:0] D_STR   = 9'(DEG_STRAIGHT);
  localparam logic [8:0] D_LEFT  = 9'(DEG_LEFT);
  localparam logic [8:0] D_RIGHT = 9'(DEG_RIGHT);
  localparam logic [8:0] D_WALL  = 9'd98;
  localparam logic [8:0] D_PK_L  = 9'd110;
  localparam logic [8:0] D_PK_R  = 9'd80;

  localparam logic [SPD_W-1:0]  MAN_HI_S    = SPD_W'(MAN_HI);
  localparam logic [SPD_W-1:0]  MAN_LO_S    = SPD_W'(MAN_LO);
  localparam logic [DIST_W-1:0] PARK_NEAR_D = DIST_W'(PARK_NEAR);
  localparam logic [DIST_W-1:0] PARK_SIDE_D = DIST_W'(PARK_SIDE);
  localparam logic [DIST_W-1:0] PARK_STOP_D = DIST_W'(PARK_STOP);
  localparam logic [DIST_W-1:0] WALL_NEAR_D = DIST_W'(WALL_NEAR);

  // GRB colours
  localparam logic [23:0] C_RED    = 24'h003C00;
  localparam logic [23:0] C_TRACK  = 24'h000050;
  localparam logic [23:0] C_WALL   = 24'h3C0000;
  localparam logic [23:0] C_PARK   = 24'h05A752;
  localparam logic [23:0] C_CRUISE = 24'h505000;

  mode_t              mode_r;
  sub_t               sub_r;
  park_t              park_r;
  logic [4:0]         man_cmd;
  logic [SPD_W-1:0]   init_spd;
  logic               speed_set;
  logic               park_done;
  logic [TIMER_W-1:0] timer;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [1:0]         signs_q;
  logic [1:0]         sign_rise;
  logic               hold_done;
  logic [CNT_W-1:0]   cnt_l, cnt_r;
  logic               cmd_man, cmd_spd, cmd_sub, cmd_auto;

  assign mode       = mode_r;
  assign sub_state  = sub_r;
  assign park_state = park_r;

  assign hold_done = (hold_cnt == HOLD_W'(STARTUP_CYC));
  assign sign_rise = signs & ~signs_q;

  // Command classes are disjoint prefixes, so decode order does not matter.
  assign cmd_man  = (rx.rx_data[7:5] == 3'b001);
  assign cmd_spd  = (rx.rx_data[7:6] == 2'b01);
  assign cmd_sub  = (rx.rx_data[7:2] == 6'b101010);
  assign cmd_auto = (rx.rx_data[7:5] == 3'b110);

  function automatic logic [SPD_W-1:0] sat_add(input logic [SPD_W-1:0] a, input int unsigned b);
    logic [SPD_W:0] s;
    s = {1'b0, a} + (SPD_W + 1)'(b);
    return s[SPD_W] ? '1 : s[SPD_W-1:0];
  endfunction

  // Count active line sensors on the left (upper) and right (lower) halves.
  always_comb begin
    cnt_l = '0;
    cnt_r = '0;
    for (int i = 0; i < N_LINE / 2; i++) begin
      cnt_r = cnt_r + CNT_W'(line_ir[i]);
      cnt_l = cnt_l + CNT_W'(line_ir[i + N_LINE / 2]);
    end
  end

  // Free-running tick: one pulse every TICK_CYC cycles, never restarted by timer loads.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_W'(TICK_CYC - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  // Startup hold counter saturates once the autonomous hold has elapsed.
  always_ff @(posedge clk_50M) begin
    if (rst) hold_cnt <= '0;
    else if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
  end

  // Mode/behaviour FSM and registered outputs; later assignments override earlier ones
  // so sign edges beat behaviour transitions and commands beat everything.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      mode_r    <= M_AUTO;
      sub_r     <= S_CRUISE;
      park_r    <= P_IDLE;
      man_cmd   <= '0;
      init_spd  <= '0;
      speed_set <= 1'b0;
      park_done <= 1'b0;
      timer     <= '0;
      signs_q   <= '0;
      speed     <= '0;
      degree    <= D_STR;
      direction <= 1'b1;
      beep_en   <= 1'b0;
      display   <= '0;
      light     <= C_RED;
    end else begin
      signs_q <= signs;
      if (tick && timer != '0) timer <= timer - 1'b1;
      if (!speed_set) init_spd <= button;

      display <= (mode_r == M_MANUAL) ? SPD_W'(fwd_dist) : init_spd;

      if (mode_r == M_MANUAL) begin
        case (man_cmd[1:0])
          2'b10:   speed <= MAN_HI_S;
          2'b01:   speed <= MAN_LO_S;
          default: speed <= '0;
        endcase
        case (man_cmd[3:2])
          2'b01:   degree <= D_RIGHT;
          2'b10:   degree <= D_LEFT;
          default: degree <= D_STR;
        endcase
        direction <= ~man_cmd[4];
        beep_en   <= 1'b0;
        light     <= C_RED;
      end else if (!hold_done) begin
        speed     <= '0;
        degree    <= D_STR;
        direction <= 1'b1;
        beep_en   <= 1'b0;
        light     <= C_RED;
      end else begin
        unique case (sub_r)
          S_TRACK: begin
            direction <= 1'b1;
            beep_en   <= 1'b0;
            light     <= C_TRACK;
            if (&line_ir) begin
              speed  <= '0;
              degree <= D_STR;
            end else begin
              speed <= init_spd;
              if (cnt_l > cnt_r)      degree <= D_LEFT;
              else if (cnt_r > cnt_l) degree <= D_RIGHT;
              else                    degree <= D_STR;
            end
          end
          S_WALL: begin
            if (timer != '0) begin
              beep_en <= 1'b1;
              light   <= C_RED;
            end else begin
              beep_en <= 1'b0;
              light   <= C_WALL;
              if (fwd_dist > WALL_NEAR_D) begin
                speed <= init_spd;
                case (touch)
                  2'b00: begin direction <= 1'b0; degree <= D_WALL;  end
                  2'b01: begin direction <= 1'b1; degree <= D_RIGHT; end
                  2'b10: begin direction <= 1'b1; degree <= D_LEFT;  end
                  default: begin direction <= 1'b1; degree <= D_WALL; end
                endcase
              end else begin
                direction <= 1'b0;
                speed     <= sat_add(init_spd, 10);
                timer     <= TIMER_W'(WALL_TICKS);
                if (side_ir[1])      degree <= D_RIGHT;
                else if (side_ir[0]) degree <= D_LEFT;
                else                 degree <= D_WALL;
              end
            end
          end
          S_PARK: begin
            light <= C_PARK;
            case (park_r)
              P_BACK1: begin
                direction <= 1'b0;
                degree    <= D_LEFT;
                speed     <= sat_add(init_spd, 8);
                beep_en   <= 1'b1;
                if (back_dist < PARK_NEAR_D) begin
                  park_r <= P_FWD;
                  timer  <= TIMER_W'(FWD_TICKS);
                end
              end
              P_FWD: begin
                direction <= 1'b1;
                degree    <= D_RIGHT;
                speed     <= sat_add(init_spd, 5);
                beep_en   <= 1'b0;
                if (timer == '0) park_r <= P_BACK2;
              end
              P_BACK2: begin
                direction <= 1'b0;
                beep_en   <= 1'b1;
                speed     <= sat_add(init_spd, 5);
                if (back_dist < PARK_SIDE_D && !side_ir[1])      degree <= D_PK_L;
                else if (back_dist < PARK_SIDE_D && !side_ir[0]) degree <= D_PK_R;
                else                                             degree <= D_STR;
                if (back_dist < PARK_STOP_D) park_r <= P_DONE;
              end
              default: begin
                speed     <= '0;
                degree    <= D_STR;
                direction <= 1'b1;
                beep_en   <= 1'b0;
                if (park_r == P_DONE) park_done <= 1'b1;
              end
            endcase
          end
          S_CRUISE: begin
            speed     <= init_spd;
            degree    <= D_STR;
            direction <= 1'b1;
            beep_en   <= 1'b0;
            light     <= C_CRUISE;
            park_done <= 1'b0;
          end
        endcase

        // Camera signs; a simultaneous command wins and the edge is dropped.
        if (!rx.rx_valid) begin
          if (sign_rise[0] && !park_done) begin
            sub_r  <= S_PARK;
            park_r <= P_BACK1;
            speed  <= '0;
          end else if (sign_rise[1]) begin
            sub_r  <= S_TRACK;
            park_r <= P_IDLE;
          end
        end
      end

      if (rx.rx_valid) begin
        if (cmd_man) begin
          mode_r  <= M_MANUAL;
          man_cmd <= rx.rx_data[4:0];
        end else if (cmd_spd) begin
          init_spd  <= SPD_W'(rx.rx_data[5:0]);
          speed_set <= 1'b1;
          mode_r    <= M_AUTO;
        end else if (cmd_sub) begin
          sub_r  <= sub_t'(rx.rx_data[1:0]);
          park_r <= (rx.rx_data[1:0] == 2'b10) ? P_BACK1 : P_IDLE;
          mode_r <= M_AUTO;
        end else if (cmd_auto) begin
          mode_r <= M_AUTO;
        end
      end
    end
  end

endmodule

// File: tb/tb_car_mode_ctrl.sv
// Purpose: exercises command decode, manual drive, track, park, wall, saturation and reset of car_mode_ctrl.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_car_mode_ctrl;
  localparam int STARTUP = 60;
  localparam int TICK    = 4;

  logic       clk_50M = 1'b0;
  logic       rst;
  logic [7:0] button, fwd_dist, back_dist;
  logic [1:0] touch, side_ir, signs;
  logic [3:0] line_ir;
  logic [7:0] speed, display;
  logic [8:0] degree;
  logic       direction, beep_en;
  logic [23:0] light;
  logic [1:0] mode, sub_state;
  logic [2:0] park_state;

  int total = 0;
  int bad   = 0;

  car_mode_ctrl_if ifc();

  car_mode_ctrl #(.STARTUP_CYC(STARTUP), .TICK_CYC(TICK)) dut (
    .clk_50M(clk_50M), .rst(rst), .rx(ifc),
    .button(button), .fwd_dist(fwd_dist), .back_dist(back_dist),
    .touch(touch), .side_ir(side_ir), .line_ir(line_ir), .signs(signs),
    .speed(speed), .degree(degree), .direction(direction), .beep_en(beep_en),
    .display(display), .light(light), .mode(mode), .sub_state(sub_state),
    .park_state(park_state)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    step(1);
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    step(1);
  endtask

  // Reference rules written from the command/sensor tables.
  function automatic int m_man_spd(input logic [7:0] b);
    int code;
    code = b % 4;
    if (code == 2) return 30;
    if (code == 1) return 15;
    return 0;
  endfunction

  function automatic int m_man_deg(input logic [7:0] b);
    int code;
    code = (b / 4) % 4;
    if (code == 1) return 60;
    if (code == 2) return 120;
    return 95;
  endfunction

  function automatic int m_track_deg(input logic [3:0] l);
    int nl, nr;
    nl = $countones(l[3:2]);
    nr = $countones(l[1:0]);
    if (nl == 2 && nr == 2) return 95;
    if (nl > nr) return 120;
    if (nr > nl) return 60;
    return 95;
  endfunction

  function automatic int m_sat(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  initial begin
    logic [7:0] b;
    logic [7:0] fd;
    logic [1:0] s;
    logic [3:0] l;
    int n;
    int init;

    rst = 1'b1; button = 8'd40; fwd_dist = 8'd100; back_dist = 8'd100;
    touch = 2'b00; side_ir = 2'b11; signs = 2'b00; line_ir = 4'b0000;
    ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    step(2);
    chk("rst_speed", speed, 0);
    chk("rst_degree", degree, 95);
    chk("rst_dir", direction, 1);
    chk("rst_light", light, 24'h003C00);
    chk("rst_mode", mode, 3);
    chk("rst_sub", sub_state, 3);
    chk("rst_park", park_state, 0);
    chk("rst_display", display, 0);
    rst = 1'b0;

    step(10);
    chk("hold_speed", speed, 0);
    chk("hold_light", light, 24'h003C00);
    step(STARTUP);
    chk("cruise_speed", speed, 40);
    chk("cruise_degree", degree, 95);
    chk("cruise_light", light, 24'h505000);
    chk("cruise_display", display, 40);

    // Manual drive
    fwd_dist = 8'd77;
    send(8'h2A);
    chk("man_speed", speed, 30);
    chk("man_degree", degree, 120);
    chk("man_dir", direction, 1);
    chk("man_display", display, 77);
    chk("man_mode", mode, 0);
    for (int i = 0; i < 5; i++) begin
      b = {3'b001, 5'($urandom)};
      fd = 8'($urandom_range(0, 255));
      fwd_dist = fd;
      send(b);
      chk("man_r_speed", speed, m_man_spd(b));
      chk("man_r_degree", degree, m_man_deg(b));
      chk("man_r_dir", direction, (b & 8'h10) ? 0 : 1);
      chk("man_r_display", display, fd);
      chk("man_r_light", light, 24'h003C00);
    end
    send(8'h80);
    chk("ignore_80", mode, 0);
    send(8'hE7);
    chk("ignore_e7", mode, 0);
    send(8'hC0);
    step(1);
    chk("resume_mode", mode, 3);
    chk("resume_speed", speed, 40);
    chk("resume_light", light, 24'h505000);

    // Speed-set then line tracking
    send(8'h54);
    button = 8'($urandom_range(60, 200));
    step(3);
    chk("spdset_display", display, 20);
    chk("spdset_speed", speed, 20);
    line_ir = 4'b1100;
    send(8'hA8);
    chk("track_sub", sub_state, 0);
    chk("track_degree", degree, 120);
    chk("track_speed", speed, 20);
    chk("track_light", light, 24'h000050);
    for (int i = 0; i < 8; i++) begin
      l = 4'($urandom);
      line_ir = l;
      step(1);
      chk("track_r_degree", degree, m_track_deg(l));
      chk("track_r_speed", speed, (l == 4'b1111) ? 0 : 20);
    end
    line_ir = 4'b1111;
    step(1);
    chk("track_all_speed", speed, 0);
    chk("track_all_degree", degree, 95);

    // Parking sequence from a camera sign
    init = 20;
    back_dist = 8'd50;
    signs = 2'b01;
    step(1);
    chk("park_sub", sub_state, 2);
    chk("park_state1", park_state, 1);
    chk("park_edge_speed", speed, 0);
    step(1);
    chk("back1_speed", speed, m_sat(init, 8));
    chk("back1_degree", degree, 120);
    chk("back1_dir", direction, 0);
    chk("back1_beep", beep_en, 1);
    chk("back1_light", light, 24'h05A752);
    back_dist = 8'd34;
    step(1);
    chk("fwd_state", park_state, 2);
    step(1);
    chk("fwd_speed", speed, m_sat(init, 5));
    chk("fwd_degree", degree, 60);
    chk("fwd_dir", direction, 1);
    n = 1;
    while (park_state !== 3'd3 && n < 200) begin
      step(1);
      n++;
    end
    chk("fwd_duration", (n > 10 * TICK && n <= 11 * TICK + 2), 1);
    s = 2'($urandom);
    side_ir = s;
    back_dist = 8'd25;
    step(1);
    chk("back2_speed", speed, m_sat(init, 5));
    chk("back2_dir", direction, 0);
    chk("back2_beep", beep_en, 1);
    chk("back2_degree", degree, (s[1] == 1'b0) ? 110 : ((s[0] == 1'b0) ? 80 : 95));
    back_dist = 8'd8;
    step(2);
    chk("done_state", park_state, 4);
    chk("done_speed", speed, 0);
    chk("done_degree", degree, 95);
    chk("done_dir", direction, 1);
    signs = 2'b00;
    step(2);
    signs = 2'b01;
    step(3);
    chk("repark_sub", sub_state, 2);
    chk("repark_state", park_state, 4);
    signs = 2'b00;

    // Wall following
    send(8'hAB);
    chk("cruise2_speed", speed, 20);
    fwd_dist = 8'd100;
    send(8'hA9);
    for (int i = 0; i < 4; i++) begin
      s = 2'($urandom);
      touch = s;
      fwd_dist = 8'($urandom_range(21, 255));
      step(1);
      chk("wall_speed", speed, 20);
      chk("wall_dir", direction, (s == 2'b00) ? 0 : 1);
      chk("wall_degree", degree, (s == 2'b01) ? 60 : ((s == 2'b10) ? 120 : 98));
      chk("wall_light", light, 24'h3C0000);
    end
    s = 2'($urandom);
    side_ir = s;
    fwd_dist = 8'd15;
    step(1);
    chk("wall_rev_dir", direction, 0);
    chk("wall_rev_speed", speed, m_sat(init, 10));
    chk("wall_rev_degree", degree, s[1] ? 60 : (s[0] ? 120 : 98));
    step(1);
    chk("wall_wait_beep", beep_en, 1);
    chk("wall_wait_light", light, 24'h003C00);
    chk("wall_wait_speed", speed, m_sat(init, 10));
    n = 0;
    while (beep_en === 1'b1 && n < 100) begin
      n++;
      step(1);
    end
    chk("wall_beep_len", (n >= 9 * TICK && n <= 10 * TICK), 1);
    step(10);
    chk("wall_rebeep", beep_en, 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_speed", speed, 0);
    chk("mid_rst_degree", degree, 95);
    chk("mid_rst_dir", direction, 1);
    chk("mid_rst_beep", beep_en, 0);
    chk("mid_rst_display", display, 0);
    chk("mid_rst_light", light, 24'h003C00);
    chk("mid_rst_mode", mode, 3);
    chk("mid_rst_sub", sub_state, 3);
    chk("mid_rst_park", park_state, 0);
    rst = 1'b0;

    // Saturation after fresh reset: init_spd follows button again
    button = 8'd250;
    back_dist = 8'd200;
    step(5);
    chk("rehold_speed", speed, 0);
    step(STARTUP);
    chk("sat_cruise", speed, 250);
    send(8'hAA);
    chk("sat_park_state", park_state, 1);
    chk("sat_back1_speed", speed, 255);
    send(8'hA8);
    chk("leave_park_state", park_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
